// File: rtl/freq_param_ctrl.sv
// freq_param_ctrl: turns two raw front-panel buttons plus a preset-load path
// into the 8-bit frequency parameter for PseudoPll. Each button is
// synchronised and debounced. A press gives one step, and a long hold gives
// auto-repeat. The value saturates at PARAM_MIN/PARAM_MAX. A one-cycle strobe
// flags each change of value.
module freq_param_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int HOLD_CYCLES     = 500000,
  parameter int REPEAT_CYCLES   = 100000,
  parameter int STEP            = 1,
  parameter int PARAM_MIN       = 0,
  parameter int PARAM_MAX       = 255,
  parameter int PARAM_RESET     = 0
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       preset_load,
  input  logic [7:0] preset_val,
  output logic [7:0] freq_param,
  output logic       param_update
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [7:0] P_MIN   = 8'(PARAM_MIN);
  localparam logic [7:0] P_MAX   = 8'(PARAM_MAX);
  localparam logic [7:0] P_RESET = 8'(PARAM_RESET);
  localparam logic [8:0] P_STEP  = 9'(STEP);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HELD   = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DOWN = 2'd2;

  // Saturating increment. The sum is 9 bits wide, so an overflow above 255
  // is still seen as "above the limit".
  function automatic logic [7:0] f_step_up(input logic [7:0] v);
    logic [8:0] sum;
    sum = {1'b0, v} + P_STEP;
    if (sum > {1'b0, P_MAX}) return P_MAX;
    return sum[7:0];
  endfunction

  // Saturating decrement. The limit is tested before subtracting, so the
  // value never wraps below zero.
  function automatic logic [7:0] f_step_down(input logic [7:0] v);
    if ({1'b0, v} < ({1'b0, P_MIN} + P_STEP)) return P_MIN;
    return v - P_STEP[7:0];
  endfunction

  function automatic logic [7:0] f_clamp(input logic [7:0] v);
    if (v < P_MIN) return P_MIN;
    if (v > P_MAX) return P_MAX;
    return v;
  endfunction

  logic [1:0] w_raw;
  logic [1:0] w_db;
  assign w_raw = {btn_down, btn_up};

  // Per-button synchroniser and debouncer. Index 0 is up, index 1 is down.
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic            r_sync1;
    logic            r_sync2;
    logic            r_db;
    logic [DB_W-1:0] r_cnt;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= w_raw[gi];
        r_sync2 <= r_sync1;
      end
    end

    // Accept a new level only after it has been stable for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_db  <= 1'b0;
      end else if (r_sync2 != r_db) begin
        if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_cnt <= '0;
          r_db  <= ~r_db;
        end else begin
          r_cnt <= r_cnt + DB_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end

    assign w_db[gi] = r_db;
  end

  logic [1:0]  r_state;
  logic [31:0] r_timer;
  logic [1:0]  r_dir;
  logic [7:0]  r_param;
  logic        r_update;

  logic [1:0]  w_dir;
  logic [1:0]  w_state_nxt;
  logic [31:0] w_timer_nxt;
  logic [1:0]  w_dir_nxt;
  logic        w_step;
  logic [7:0]  w_param_nxt;

  // Direction: pressing both buttons counts as no direction
  always_comb begin
    w_dir = DIR_NONE;
    if (w_db[0] && !w_db[1]) w_dir = DIR_UP;
    else if (w_db[1] && !w_db[0]) w_dir = DIR_DOWN;
  end

  // Press / hold / repeat sequencing, then the next parameter value
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_dir_nxt   = r_dir;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dir != DIR_NONE) begin
          w_step      = 1'b1;
          w_timer_nxt = '0;
          w_dir_nxt   = w_dir;
          w_state_nxt = S_HELD;
        end
      end
      S_HELD: begin
        if (w_dir == DIR_NONE || w_dir != r_dir) begin
          // A direction change always passes through one IDLE cycle
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
          w_dir_nxt   = DIR_NONE;
        end else if (r_timer == 32'(HOLD_CYCLES - 1)) begin
          w_step      = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = S_REPEAT;
        end else begin
          w_timer_nxt = r_timer + 32'd1;
        end
      end
      S_REPEAT: begin
        if (w_dir == DIR_NONE || w_dir != r_dir) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
          w_dir_nxt   = DIR_NONE;
        end else if (r_timer == 32'(REPEAT_CYCLES - 1)) begin
          w_step      = 1'b1;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 32'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
        w_dir_nxt   = DIR_NONE;
      end
    endcase

    // A preset overrides any step due in the same cycle. The sequencer
    // above still advances as though the step had happened.
    w_param_nxt = r_param;
    if (preset_load) begin
      w_param_nxt = f_clamp(preset_val);
    end else if (w_step) begin
      w_param_nxt = (w_dir == DIR_UP) ? f_step_up(r_param) : f_step_down(r_param);
    end
  end

  // Sequencer state, parameter register and change strobe
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_dir    <= DIR_NONE;
      r_param  <= P_RESET;
      r_update <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_dir    <= w_dir_nxt;
      r_param  <= w_param_nxt;
      r_update <= (w_param_nxt != r_param);
    end
  end

  assign freq_param   = r_param;
  assign param_update = r_update;

endmodule

// File: tb/tb_freq_param_ctrl.sv
// Testbench for freq_param_ctrl. There are two instances: STEP=1 with limits
// 0..255, and STEP=3 with limits 0..250. Both share the same stimulus. A
// schedule-based reference model pushes each expected new value into a
// per-instance queue. A monitor pops from the queue whenever the DUT strobes
// param_update.
module tb_freq_param_ctrl;
  localparam int DC  = 4;
  localparam int HC  = 20;
  localparam int RC  = 5;
  localparam int ST0 = 1;
  localparam int ST1 = 3;
  localparam int MX0 = 255;
  localparam int MX1 = 250;
  localparam int MN  = 0;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_down, preset_load;
  logic [7:0] preset_val;
  logic [7:0] fp0, fp1;
  logic       pu0, pu1;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  freq_param_ctrl #(.DEBOUNCE_CYCLES(DC), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC),
    .STEP(ST0), .PARAM_MIN(MN), .PARAM_MAX(MX0), .PARAM_RESET(0)) dut0 (
    .clk_in(clk_in), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
    .preset_load(preset_load), .preset_val(preset_val),
    .freq_param(fp0), .param_update(pu0));

  freq_param_ctrl #(.DEBOUNCE_CYCLES(DC), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC),
    .STEP(ST1), .PARAM_MIN(MN), .PARAM_MAX(MX1), .PARAM_RESET(0)) dut1 (
    .clk_in(clk_in), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
    .preset_load(preset_load), .preset_val(preset_val),
    .freq_param(fp1), .param_update(pu1));

  // ---------------- reference model ----------------
  int m_db[2], m_run[2], m_s1[2], m_s2[2];
  int m_active, m_start, m_n;
  int m_exp[2];
  int q0[$];
  int q1[$];
  int pcnt[2];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_db[b] = 0; m_run[b] = 0; m_s1[b] = 0; m_s2[b] = 0; m_exp[b] = 0;
    end
    m_active = 0; m_start = 0; m_n = 0;
    q0.delete();
    q1.delete();
  endtask

  // Step timing is a fixed schedule counted from the first step of a press:
  // offsets 0, HC, HC+RC, HC+2*RC, ...
  task automatic model_step();
    int dir, el, nv, st, mx, raw[2];
    bit step;
    raw[0] = int'(btn_up);
    raw[1] = int'(btn_down);
    dir = (m_db[0] == 1 && m_db[1] == 0) ? 1 : (m_db[1] == 1 && m_db[0] == 0) ? 2 : 0;
    step = 0;
    if (m_active == 0) begin
      if (dir != 0) begin
        step = 1; m_active = dir; m_start = m_n;
      end
    end else if (dir != m_active) begin
      m_active = 0;
    end else begin
      el = m_n - m_start;
      if (el == HC || (el > HC && (el - HC) % RC == 0)) step = 1;
    end
    for (int b = 0; b < 2; b++) begin
      if (m_s2[b] != m_db[b]) begin
        m_run[b]++;
        if (m_run[b] == DC) begin
          m_db[b] = 1 - m_db[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
    for (int ch = 0; ch < 2; ch++) begin
      st = (ch == 0) ? ST0 : ST1;
      mx = (ch == 0) ? MX0 : MX1;
      nv = m_exp[ch];
      if (preset_load) begin
        nv = int'(preset_val);
        if (nv < MN) nv = MN;
        if (nv > mx) nv = mx;
      end else if (step) begin
        if (m_active == 1) nv = (m_exp[ch] + st > mx) ? mx : m_exp[ch] + st;
        else               nv = (m_exp[ch] - st < MN) ? MN : m_exp[ch] - st;
      end
      if (nv != m_exp[ch]) begin
        if (ch == 0) q0.push_back(nv);
        else         q1.push_back(nv);
      end
      m_exp[ch] = nv;
    end
    m_n++;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk_in) if (rst_n) model_step();

  // ---------------- monitor ----------------
  always @(negedge clk_in) begin
    if (rst_n) begin
      int v;
      if (pu0) begin
        pcnt[0]++;
        if (q0.size() == 0) chk("dut0_unexpected_update", int'(fp0), m_exp[0]);
        else begin v = q0.pop_front(); chk("dut0_update_value", int'(fp0), v); end
      end
      if (pu1) begin
        pcnt[1]++;
        if (q1.size() == 0) chk("dut1_unexpected_update", int'(fp1), m_exp[1]);
        else begin v = q1.pop_front(); chk("dut1_update_value", int'(fp1), v); end
      end
      chk("dut0_param_track", int'(fp0), m_exp[0]);
      chk("dut1_param_track", int'(fp1), m_exp[1]);
      chk("dut0_missed_update", q0.size(), 0);
      chk("dut1_missed_update", q1.size(), 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int k);
    repeat (k) @(negedge clk_in);
  endtask

  task automatic preset(input int v);
    preset_val  = 8'(v);
    preset_load = 1'b1;
    cyc(1);
    preset_load = 1'b0;
  endtask

  initial begin
    int p0, p1, a, b;
    pcnt[0] = 0; pcnt[1] = 0;
    model_reset();
    rst_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    preset_load = 1'b0; preset_val = 8'd0;
    cyc(3);
    chk("reset_fp0", int'(fp0), 0);
    chk("reset_pu0", int'(pu0), 0);
    chk("reset_fp1", int'(fp1), 0);
    chk("reset_pu1", int'(pu1), 0);
    rst_n = 1'b1;
    cyc(3);

    // single press gives a single step
    p0 = pcnt[0]; p1 = pcnt[1];
    btn_up = 1'b1; cyc(10); btn_up = 1'b0; cyc(30);
    chk("t1_pulses0", pcnt[0] - p0, 1);
    chk("t1_value0", int'(fp0), 1);
    chk("t1_value1", int'(fp1), 3);

    // short glitches are rejected
    p0 = pcnt[0]; p1 = pcnt[1];
    repeat (6) begin btn_up = 1'b1; cyc(3); btn_up = 1'b0; cyc(3); end
    cyc(20);
    chk("t2_pulses0", pcnt[0] - p0, 0);
    chk("t2_pulses1", pcnt[1] - p1, 0);

    // long hold: first step, hold delay, then repeat
    p0 = pcnt[0]; p1 = pcnt[1];
    btn_up = 1'b1; cyc(60); btn_up = 1'b0; cyc(20);
    chk("t3_steps0", pcnt[0] - p0, 9);
    chk("t3_steps1", pcnt[1] - p1, 9);
    chk("t3_value0", int'(fp0), 10);

    // preset near the top, then saturate
    p0 = pcnt[0]; p1 = pcnt[1];
    preset(254);
    btn_up = 1'b1; cyc(80); btn_up = 1'b0; cyc(20);
    chk("t4_pulses0", pcnt[0] - p0, 2);
    chk("t4_pulses1", pcnt[1] - p1, 1);
    chk("t4_value0", int'(fp0), 255);
    chk("t4_value1", int'(fp1), 250);

    // down to the lower limit without wrap, then both buttons held
    p0 = pcnt[0]; p1 = pcnt[1];
    preset(1);
    btn_down = 1'b1; cyc(40);
    btn_up = 1'b1; cyc(40);
    btn_up = 1'b0; btn_down = 1'b0; cyc(20);
    chk("t5_pulses0", pcnt[0] - p0, 2);
    chk("t5_pulses1", pcnt[1] - p1, 2);
    chk("t5_value0", int'(fp0), 0);
    chk("t5_value1", int'(fp1), 0);

    // asynchronous reset during repeat, button still held afterwards
    preset(40);
    btn_up = 1'b1; cyc(40);
    @(posedge clk_in); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_fp0", int'(fp0), 0);
    chk("t6_async_pu0", int'(pu0), 0);
    chk("t6_async_fp1", int'(fp1), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    chk("t6_before_step", int'(fp0), 0);
    cyc(1);
    chk("t6_first_step", int'(fp0), 1);
    btn_up = 1'b0; cyc(20);

    // randomized button and preset activity
    repeat (250) begin
      a = $urandom_range(0, 3);
      btn_up   = a[0];
      btn_down = a[1];
      b = $urandom_range(1, 40);
      if ($urandom_range(0, 7) == 0) preset($urandom_range(0, 255));
      cyc(b);
    end
    btn_up = 1'b0; btn_down = 1'b0;
    cyc(30);
    chk("end_q0_empty", q0.size(), 0);
    chk("end_q1_empty", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
